ms_cmd_dec_pipe: RTL

- Parametrised successor to the dual-ISA command decode stage.
- Accepts NCH packed decoder bundles, one per ISA decoder. Selects one by ACpuType with a strict index mux, not by ORing.
- Sequences multi-step commands and arbitrates the unity (exclusive) handshake.
- Holds the chosen VLIW bundle in a registered valid/ready output slot that feeds the execute stage.

---
 rtl/ms_cmd_dec_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ms_cmd_dec_pipe.sv
// ms_cmd_dec_pipe: parametrised command decode stage.
//
// Picks one of NCH packed decoder bundles by ACpuType (strict index mux),
// sequences multi-step commands with a step watchdog, arbitrates the unity
// (exclusive) handshake and holds the chosen VLIW bundle in a registered
// valid/ready slot that feeds the execute stage.
//
// Optional feature macro: MS_CMD_DEC_STAT_EN (issued-command counter on AStatCmdCnt).
//
// Ports:
//   AClkH, AResetHN        clock, asynchronous active-low reset
//   ACpuType               channel select; ACpuTypeErr flags an out-of-range select
//   ADecVliw/ADecCmdLen/
//   ADecStepNext/ADecUnityReq  per-channel decoder bundles, channel k at slice k
//   AQueValid/AQueUsed/AQueUsedLen  fetch queue handshake (consume pulse + length)
//   AStepThis              current step code fed back to the decoders
//   AUnityReq/AUnityAck    exclusive execution handshake
//   AMemPend, AFlush       issue block, pipeline flush
//   AExecVliw/AExecValid/AExecReady  registered output slot
//   AStepErr               one-cycle pulse when the step watchdog trips
//   AStatCmdCnt            issued-command counter (0 when the feature is off)
module ms_cmd_dec_pipe #(
   parameter int unsigned NCH      = 2,
   parameter int unsigned VLIW_W   = 160,
   parameter int unsigned STEP_W   = 10,
   parameter int unsigned TYPE_W   = 2,
   parameter int unsigned STEP_MAX = 64
) (
   input  logic                    AClkH,
   input  logic                    AResetHN,
   input  logic [TYPE_W-1:0]       ACpuType,
   input  logic [NCH*VLIW_W-1:0]   ADecVliw,
   input  logic [NCH*2-1:0]        ADecCmdLen,
   input  logic [NCH*STEP_W-1:0]   ADecStepNext,
   input  logic [NCH-1:0]          ADecUnityReq,
   input  logic                    AQueValid,
   output logic                    AQueUsed,
   output logic [1:0]              AQueUsedLen,
   output logic [STEP_W-1:0]       AStepThis,
   output logic                    AUnityReq,
   input  logic                    AUnityAck,
   input  logic                    AMemPend,
   input  logic                    AFlush,
   output logic [VLIW_W-1:0]       AExecVliw,
   output logic                    AExecValid,
   input  logic                    AExecReady,
   output logic                    ACpuTypeErr,
   output logic                    AStepErr,
   output logic [31:0]             AStatCmdCnt
);

   localparam int unsigned CntW = $clog2(STEP_MAX + 1);

   typedef enum logic {StRun, StUnity} stateT;

   stateT             state;
   logic [CntW-1:0]   stepCnt;

   logic [VLIW_W-1:0] selVliw;
   logic [1:0]        selLen;
   logic [STEP_W-1:0] selStep;
   logic              selUnity;
   logic              slotFree;
   logic              go;
   logic              unityStart;
   logic              capture;

   assign ACpuTypeErr = (32'(ACpuType) >= NCH);

   // Equality-decoded mux: an out-of-range select matches no channel, so the
   // selected fields fall back to zero.
   always_comb begin
      selVliw  = '0;
      selLen   = '0;
      selStep  = '0;
      selUnity = 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (32'(ACpuType) == k) begin
            selVliw  = ADecVliw[k*VLIW_W +: VLIW_W];
            selLen   = ADecCmdLen[k*2 +: 2];
            selStep  = ADecStepNext[k*STEP_W +: STEP_W];
            selUnity = ADecUnityReq[k];
         end
      end
   end

   assign slotFree   = !AExecValid || AExecReady;
   assign go         = (state == StRun) && AQueValid && slotFree && !AMemPend && !ACpuTypeErr;
   // A held AUnityReq means the grant already arrived: the command issues this time.
   assign unityStart = go && selUnity && !AUnityReq;
   assign capture    = go && !unityStart;

   always_ff @(posedge AClkH or negedge AResetHN) begin
      if (!AResetHN) begin
         state       <= StRun;
         stepCnt     <= '0;
         AQueUsed    <= 1'b0;
         AQueUsedLen <= '0;
         AStepThis   <= '0;
         AUnityReq   <= 1'b0;
         AExecVliw   <= '0;
         AExecValid  <= 1'b0;
         AStepErr    <= 1'b0;
      end else begin
         AQueUsed <= 1'b0;
         AStepErr <= 1'b0;
         if (AFlush) begin
            // AExecVliw deliberately keeps its last value.
            state      <= StRun;
            stepCnt    <= '0;
            AStepThis  <= '0;
            AUnityReq  <= 1'b0;
            AExecValid <= 1'b0;
         end else begin
            if (capture) begin
               AExecVliw  <= selVliw;
               AExecValid <= 1'b1;
               AUnityReq  <= 1'b0;
               if (selStep == '0) begin
                  AQueUsed    <= 1'b1;
                  AQueUsedLen <= selLen;
                  AStepThis   <= '0;
                  stepCnt     <= '0;
               end else if (stepCnt == CntW'(STEP_MAX - 1)) begin
                  // Runaway command: force completion so the queue advances.
                  AStepErr    <= 1'b1;
                  AQueUsed    <= 1'b1;
                  AQueUsedLen <= selLen;
                  AStepThis   <= '0;
                  stepCnt     <= '0;
               end else begin
                  AStepThis <= selStep;
                  stepCnt   <= stepCnt + CntW'(1);
               end
            end else if (AExecReady) begin
               // Slot drains whenever nothing new is captured.
               AExecValid <= 1'b0;
            end

            if (unityStart) begin
               AUnityReq <= 1'b1;
               state     <= StUnity;
            end else if (state == StUnity && AUnityAck) begin
               state <= StRun;
            end
         end
      end
   end

`ifdef MS_CMD_DEC_STAT_EN
   logic [31:0] statCnt;

   // Counts consume pulses after they are registered, so flush never hides one.
   always_ff @(posedge AClkH or negedge AResetHN) begin
      if (!AResetHN) begin
         statCnt <= '0;
      end else if (AQueUsed) begin
         statCnt <= statCnt + 32'd1;
      end
   end

   assign AStatCmdCnt = statCnt;
`else
   assign AStatCmdCnt = '0;
`endif

endmodule
